signed_adder_pipe: RTL
======================

Name: signed_adder_pipe

Overview:
Multi-lane, pipelined signed fixed-point adder and accumulator with a valid/ready handshake. Each lane computes either a+b or a running sum acc+a, and either saturates or wraps the result at OUT_WIDTH. Per-lane sticky overflow flags are kept. It sits between the MAC array outputs and the output buffer and replaces single-lane adders where back-pressure or accumulation is needed.

Parameters:
NUM_LANES, 4, number of independent adder lanes
IN1_WIDTH, 20, width of each signed a operand
IN2_WIDTH, 32, width of each signed b operand
OUT_WIDTH, 32, width of each signed result and accumulator
PIPE_STAGES, 2, register stages from accept to output; legal range 1..4
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
mode  input  1  0 = add (a+b), 1 = accumulate (acc+a); sampled per accepted beat
acc_clear  input  1  on an accepted accumulate beat, treat acc as 0 before adding
a  input  NUM_LANES*IN1_WIDTH  lane i occupies bits [i*IN1_WIDTH +: IN1_WIDTH]
b  input  NUM_LANES*IN2_WIDTH  lane i occupies bits [i*IN2_WIDTH +: IN2_WIDTH]; ignored when mode=1
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out  output  NUM_LANES*OUT_WIDTH  lane results, packed as for a
ovf_sticky  output  NUM_LANES  per-lane overflow seen since last clear
ovf_clear  input  1  clears all ovf_sticky bits

Behaviour:
- Accept: a beat is accepted when in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !reset && (!stage_valid[PIPE_STAGES-1] || out_ready). The pipeline stalls as a whole; no stage advances while stalled. No beat is dropped or duplicated.
- Latency: with no stall, out_valid rises exactly PIPE_STAGES cycles after the accept edge. Throughput is 1 beat/cycle while out_ready=1.
- out and out_valid are registered, and out holds stable while out_valid && !out_ready.
- Arithmetic:
  - Operands are sign-extended to W = max(IN1_WIDTH, IN2_WIDTH, OUT_WIDTH)+1 and summed at full precision.
  - Overflow = sum > 2^(OUT_WIDTH-1)-1 or sum < -2^(OUT_WIDTH-1).
  - SATURATE=1: clamp to max or min. SATURATE=0: keep the low OUT_WIDTH bits.
- Accumulate mode:
  - Per-lane acc register is updated at the accept edge: acc <= result(acc_clear ? a : acc + a), where result() applies the saturate/wrap rule.
  - The output beat carries the updated acc value.
  - Consecutive accumulate beats use the acc value from the previous beat, with no hazard.
  - acc is unchanged by mode=0 beats.
- Overflow flags: ovf_sticky[i] is set on the accept edge of any beat whose lane i overflowed, and stays set until ovf_clear. If set and clear occur in the same cycle, set wins. Flags are updated at accept and are not delayed by the pipeline.
- Mode may change on any beat; each beat uses its own sampled mode and acc_clear.
- Reset (synchronous, any cycle including mid-stream): all stage valids 0, out_valid=0, out=0, acc=0, ovf_sticky=0, in_ready=0 while reset is high. In-flight beats are discarded. Beats presented during reset are not accepted.
- Inputs are not required to be stable when in_valid=0.

Test Plan:
- Add, no stall, SATURATE=1, PIPE_STAGES=2: lane0 a=5, b=-3 -> out lane0=2, out_valid 2 cycles after accept; all lanes independent with distinct values.
- Saturation: a=1, b=0x7FFFFFFF -> lane result 0x7FFFFFFF, ovf_sticky[lane]=1. a=-1 (20-bit 0xFFFFF), b=0x80000000 -> 0x80000000. With SATURATE=0 the same stimulus gives 0x80000000 and 0x7FFFFFFF, and the flag is still set.
- Accumulate: mode=1 beats a=10 (acc_clear=1), 20, -5 -> outputs 10, 30, 25. Then a=7 with acc_clear=1 -> 7. An intervening mode=0 beat leaves acc unchanged.
- Back-pressure: stream 8 beats with out_ready toggling 1,0,0,1 and random in_valid -> all 8 results in order, none lost or duplicated. in_ready=0 exactly when the last stage is full and out_ready=0. out stays stable during stalls.
- Flag clear race: ovf_clear=1 in the same cycle as an overflowing accept -> flag stays 1. ovf_clear alone -> 0 next cycle.
- Reset mid-stream: assert reset with 2 beats in flight -> out_valid=0 and acc=0 the next cycle, no stale beat appears after release, and the first post-reset accumulate of a=3 gives 3.

Source files
------------

// File: rtl/signed_adder_pipe.sv
// Multi-lane pipelined signed adder/accumulator with valid/ready flow control.
// One lane instance per lane; the lane holds its accumulator and resolves saturate/wrap at accept.

module signed_adder_lane #(
  parameter int IN1_WIDTH = 20,
  parameter int IN2_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 accept,
  input  logic                 mode,
  input  logic                 acc_clear,
  input  logic [IN1_WIDTH-1:0] a,
  input  logic [IN2_WIDTH-1:0] b,
  output logic [OUT_WIDTH-1:0] res,
  output logic                 ovf
);
  localparam int MX12 = (IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH;
  localparam int MX   = (MX12 > OUT_WIDTH) ? MX12 : OUT_WIDTH;
  localparam int W    = MX + 1;
  localparam logic [OUT_WIDTH-1:0] MAXV = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MINV = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH-1:0] acc;
  logic [W-1:0] a_x, b_x, acc_x, op, sum;
  logic         fits;

  always_comb begin
    a_x   = {{(W-IN1_WIDTH){a[IN1_WIDTH-1]}}, a};
    b_x   = {{(W-IN2_WIDTH){b[IN2_WIDTH-1]}}, b};
    acc_x = {{(W-OUT_WIDTH){acc[OUT_WIDTH-1]}}, acc};
    op    = mode ? (acc_clear ? '0 : acc_x) : b_x;
    sum   = a_x + op;
    // in range iff every bit from the output sign bit upward agrees
    fits  = (&sum[W-1:OUT_WIDTH-1]) || !(|sum[W-1:OUT_WIDTH-1]);
    ovf   = !fits;
    res   = sum[OUT_WIDTH-1:0];
    if (ovf && (SATURATE != 0)) res = sum[W-1] ? MINV : MAXV;
  end

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (accept && mode) acc <= res;
  end
endmodule

module signed_adder_pipe #(
  parameter int NUM_LANES   = 4,
  parameter int IN1_WIDTH   = 20,
  parameter int IN2_WIDTH   = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int PIPE_STAGES = 2,
  parameter int SATURATE    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           mode,
  input  logic                           acc_clear,
  input  logic [NUM_LANES*IN1_WIDTH-1:0] a,
  input  logic [NUM_LANES*IN2_WIDTH-1:0] b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*OUT_WIDTH-1:0] out,
  output logic [NUM_LANES-1:0]           ovf_sticky,
  input  logic                           ovf_clear
);
  localparam int P = PIPE_STAGES;

  logic [P:1]                               vld_pipe;
  logic [P:1][NUM_LANES-1:0][OUT_WIDTH-1:0] dat_pipe;
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0]      lane_res;
  logic [NUM_LANES-1:0]                     lane_ovf;
  logic                                     stall, accept;

  // whole-pipe stall: nothing moves while the output beat is held
  assign stall    = vld_pipe[P] && !out_ready;
  assign in_ready = !reset && !stall;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    signed_adder_lane #(
      .IN1_WIDTH(IN1_WIDTH), .IN2_WIDTH(IN2_WIDTH),
      .OUT_WIDTH(OUT_WIDTH), .SATURATE(SATURATE)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .accept   (accept),
      .mode     (mode),
      .acc_clear(acc_clear),
      .a        (a[i*IN1_WIDTH +: IN1_WIDTH]),
      .b        (b[i*IN2_WIDTH +: IN2_WIDTH]),
      .res      (lane_res[i]),
      .ovf      (lane_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      dat_pipe   <= '0;
      ovf_sticky <= '0;
    end else begin
      if (!stall) begin
        vld_pipe[1] <= accept;
        dat_pipe[1] <= lane_res;
        for (int s = 2; s <= P; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          dat_pipe[s] <= dat_pipe[s-1];
        end
      end
      // a fresh overflow beats a simultaneous clear
      ovf_sticky <= (ovf_sticky & ~{NUM_LANES{ovf_clear}}) | (lane_ovf & {NUM_LANES{accept}});
    end
  end

  assign out_valid = vld_pipe[P];
  assign out       = dat_pipe[P];
endmodule
